mt_barrel_sched: RTL

- Parametrised thread scheduler and PC bank for the barrel multithreaded CPU.
- Each cycle it picks the next eligible hardware thread round-robin and issues that thread's PC to fetch.
- Skips stalled and halted threads; accepts per-thread branch redirects and halts from later stages.
- Generalises the fixed 4-thread strict rotation: any thread count, per-thread stall, halt detection, and an all-halted flag for simulation end.

---
 rtl/mt_pkg.sv | 14 +
 rtl/mt_rr_pick.sv | 28 ++
 rtl/mt_barrel_sched.sv | 112 +++++++++++
 3 files changed

// File: rtl/mt_pkg.sv
// Shared definitions for the barrel-CPU thread scheduler and the blocks that reuse its picker.
package mt_pkg;

  localparam int unsigned INSTR_BYTES = 4;
  localparam int unsigned MAX_TID_W   = 8;

  typedef logic [MAX_TID_W-1:0] tid_t;

  // A thread id is always at least one bit wide, even for a single-thread build.
  function automatic int unsigned tid_width(input int unsigned n);
    return (n <= 32'd2) ? 32'd1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/mt_rr_pick.sv
// Combinational rotating-priority picker: first set bit of elig after last_tid, wrapping modulo N.
module mt_rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] elig,
  input  logic [W-1:0] last_tid,
  output logic         pick_valid,
  output logic [W-1:0] pick_tid
);

  int unsigned idx;

  // Modulo keeps the scan correct for thread counts that are not a power of two.
  always_comb begin
    pick_valid = 1'b0;
    pick_tid   = '0;
    idx        = 0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(last_tid) + i) % N;
      if (!pick_valid && elig[idx]) begin
        pick_valid = 1'b1;
        pick_tid   = W'(idx);
      end
    end
  end

endmodule

// File: rtl/mt_barrel_sched.sv
// mt_barrel_sched: round-robin thread scheduler and per-thread PC bank for the barrel CPU.
// Define MT_SCHED_PERF_EN to add per-thread issue counters and an idle-cycle counter.
module mt_barrel_sched
  import mt_pkg::*;
#(
  parameter int unsigned              NUM_THREADS   = 4,
  parameter int unsigned              ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter logic [ADDRESS_WIDTH-1:0] PC_STRIDE     = ADDRESS_WIDTH'(32'h100),
  localparam int unsigned             TID_W         = tid_width(NUM_THREADS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_THREADS-1:0]   stall_i,
  input  logic                     halt_valid_i,
  input  logic [TID_W-1:0]         halt_tid_i,
  input  logic                     redir_valid_i,
  input  logic [TID_W-1:0]         redir_tid_i,
  input  logic [ADDRESS_WIDTH-1:0] redir_pc_i,
  output logic                     issue_valid_o,
  output logic [TID_W-1:0]         issue_tid_o,
  output logic [ADDRESS_WIDTH-1:0] issue_pc_o,
  output logic [NUM_THREADS-1:0]   active_mask_o,
  output logic                     all_halted_o
`ifdef MT_SCHED_PERF_EN
  ,
  output logic [NUM_THREADS*32-1:0] perf_issue_cnt_o,
  output logic [31:0]               perf_idle_cnt_o
`endif
);

  logic [ADDRESS_WIDTH-1:0] pc [NUM_THREADS];
  logic [NUM_THREADS-1:0]   active;
  logic [NUM_THREADS-1:0]   active_next;
  logic [NUM_THREADS-1:0]   elig;
  logic [TID_W-1:0]         last_tid;
  logic                     pick_valid;
  logic [TID_W-1:0]         pick_tid;
  logic                     halt_ok;
  logic                     redir_ok;

  assign halt_ok       = halt_valid_i  && (32'(halt_tid_i)  < NUM_THREADS);
  assign redir_ok      = redir_valid_i && (32'(redir_tid_i) < NUM_THREADS);
  assign active_mask_o = active;

  // A thread halted this cycle is already excluded from this cycle's pick.
  always_comb begin
    elig = '0;
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      elig[t] = active[t] & ~stall_i[t] & ~(halt_valid_i && (32'(halt_tid_i) == t));
    end
  end

  always_comb begin
    active_next = active;
    if (halt_ok) begin
      active_next[halt_tid_i] = 1'b0;
    end
  end

  mt_rr_pick #(
    .N (NUM_THREADS),
    .W (TID_W)
  ) u_pick (
    .elig       (elig),
    .last_tid   (last_tid),
    .pick_valid (pick_valid),
    .pick_tid   (pick_tid)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      issue_valid_o <= 1'b0;
      issue_tid_o   <= '0;
      issue_pc_o    <= '0;
      active        <= '1;
      all_halted_o  <= 1'b0;
      last_tid      <= TID_W'(NUM_THREADS - 1);
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        pc[t] <= RESET_PC + ADDRESS_WIDTH'(t) * PC_STRIDE;
      end
`ifdef MT_SCHED_PERF_EN
      perf_issue_cnt_o <= '0;
      perf_idle_cnt_o  <= '0;
`endif
    end else begin
      if (pick_valid) begin
        issue_valid_o  <= 1'b1;
        issue_tid_o    <= pick_tid;
        issue_pc_o     <= pc[pick_tid];
        last_tid       <= pick_tid;
        pc[pick_tid]   <= pc[pick_tid] + ADDRESS_WIDTH'(INSTR_BYTES);
      end else begin
        issue_valid_o <= 1'b0;
      end
      // Issued above with the old PC; a same-cycle redirect replaces the +4.
      if (redir_ok) begin
        pc[redir_tid_i] <= redir_pc_i;
      end
      active       <= active_next;
      all_halted_o <= (active_next == '0);
`ifdef MT_SCHED_PERF_EN
      if (pick_valid) begin
        perf_issue_cnt_o[32*pick_tid +: 32] <= perf_issue_cnt_o[32*pick_tid +: 32] + 32'd1;
      end else if (active_next != '0) begin
        perf_idle_cnt_o <= perf_idle_cnt_o + 32'd1;
      end
`endif
    end
  end

endmodule
